// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/empty levels,
// occupancy count, sticky overflow/underflow flags and selectable FWFT output.
module sync_fifo_flex #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0,
    localparam int CNT_WIDTH = $clog2(DEPTH + 1),
    localparam int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR_EN,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  RD_EN,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [CNT_WIDTH-1:0]  COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW,
    input  logic                  CLR_ERR
);

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_AF   = CNT_WIDTH'(AF_LEVEL);
    localparam logic [CNT_WIDTH-1:0] CNT_AE   = CNT_WIDTH'(AE_LEVEL);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(DEPTH - 1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 af_q, af_d;
    logic                 ae_q, ae_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 rd_ok, wr_ok;

    always_comb begin
        rd_ok = RD_EN && (count_q != '0);
        // A full FIFO can still take a write when the same cycle frees a slot.
        wr_ok = WR_EN && ((count_q != CNT_FULL) || rd_ok);

        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CNT_ONE;
        end

        wr_ptr_d = wr_ptr_q;
        if (wr_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        end
        rd_ptr_d = rd_ptr_q;
        if (rd_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
        end

        // Flags are registered from the next count so they never glitch.
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
        af_d    = (count_d >= CNT_AF);
        ae_d    = (count_d <= CNT_AE);

        // A new error event takes priority over a coincident clear.
        overflow_d = overflow_q;
        if (WR_EN && !wr_ok) begin
            overflow_d = 1'b1;
        end else if (CLR_ERR) begin
            overflow_d = 1'b0;
        end
        underflow_d = underflow_q;
        if (RD_EN && !rd_ok) begin
            underflow_d = 1'b1;
        end else if (CLR_ERR) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= WR_DATA;
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
            logic                  rd_valid_q, rd_valid_d;

            always_comb begin
                rd_data_d  = rd_data_q;
                rd_valid_d = rd_ok;
                if (rd_ok) begin
                    rd_data_d = mem[rd_ptr_q];
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_data_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign RD_DATA  = rd_data_q;
            assign RD_VALID = rd_valid_q;
        end else begin : g_fwft
            // Head word is shown directly; blanked while empty so stale storage never leaks out.
            assign RD_DATA  = empty_q ? '0 : mem[rd_ptr_q];
            assign RD_VALID = !empty_q;
        end
    endgenerate

    assign COUNT        = count_q;
    assign FULL         = full_q;
    assign EMPTY        = empty_q;
    assign ALMOST_FULL  = af_q;
    assign ALMOST_EMPTY = ae_q;
    assign OVERFLOW     = overflow_q;
    assign UNDERFLOW    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench: a DEPTH=8 standard-mode FIFO and a DEPTH=5 FWFT FIFO side by side.
module tb_sync_fifo_flex;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // DEPTH=8, standard mode
    logic        s_rst, s_wr_en, s_rd_en, s_clr;
    logic [15:0] s_wr_data, s_rd_data;
    logic        s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [3:0]  s_count;

    // DEPTH=5, FWFT mode
    logic        f_rst, f_wr_en, f_rd_en, f_clr;
    logic [15:0] f_wr_data, f_rd_data;
    logic        f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [2:0]  f_count;

    sync_fifo_flex #(
        .DATA_WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)
    ) u_std (
        .CLK(clk), .RST(s_rst), .WR_EN(s_wr_en), .WR_DATA(s_wr_data),
        .RD_EN(s_rd_en), .RD_DATA(s_rd_data), .RD_VALID(s_rd_valid),
        .FULL(s_full), .EMPTY(s_empty), .ALMOST_FULL(s_af), .ALMOST_EMPTY(s_ae),
        .COUNT(s_count), .OVERFLOW(s_ovf), .UNDERFLOW(s_unf), .CLR_ERR(s_clr)
    );

    sync_fifo_flex #(
        .DATA_WIDTH(16), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1)
    ) u_fwft (
        .CLK(clk), .RST(f_rst), .WR_EN(f_wr_en), .WR_DATA(f_wr_data),
        .RD_EN(f_rd_en), .RD_DATA(f_rd_data), .RD_VALID(f_rd_valid),
        .FULL(f_full), .EMPTY(f_empty), .ALMOST_FULL(f_af), .ALMOST_EMPTY(f_ae),
        .COUNT(f_count), .OVERFLOW(f_ovf), .UNDERFLOW(f_unf), .CLR_ERR(f_clr)
    );

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        s_rst = 1'b1; s_wr_en = 1'b0; s_rd_en = 1'b0; s_clr = 1'b0; s_wr_data = '0;
        f_rst = 1'b1; f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr = 1'b0; f_wr_data = '0;
        tick();
        tick();
        s_rst = 1'b0;
        f_rst = 1'b0;
        checks++;
        if ({s_count, s_empty, s_full, s_ae, s_af} !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_std_flags got cnt=%0d e=%b f=%b ae=%b af=%b want cnt=0 e=1 f=0 ae=1 af=0",
                     s_count, s_empty, s_full, s_ae, s_af);
        end
        checks++;
        if ({s_rd_data, s_rd_valid, s_ovf, s_unf} !== {16'h0000, 3'b000}) begin
            failures++;
            $display("FAIL reset_std_out got data=%h v=%b ovf=%b unf=%b want 0000 0 0 0",
                     s_rd_data, s_rd_valid, s_ovf, s_unf);
        end
        checks++;
        if ({f_count, f_empty, f_rd_valid, f_rd_data} !== {3'd0, 1'b1, 1'b0, 16'h0000}) begin
            failures++;
            $display("FAIL reset_fwft got cnt=%0d e=%b v=%b data=%h want 0 1 0 0000",
                     f_count, f_empty, f_rd_valid, f_rd_data);
        end
        $display("reset: std cnt=%0d empty=%b, fwft cnt=%0d empty=%b", s_count, s_empty, f_count, f_empty);
    endtask

    task automatic test_fill_drain();
        logic [15:0] exp_data;
        for (int i = 1; i <= 8; i++) begin
            s_wr_en = 1'b1;
            s_wr_data = 16'(i);
            tick();
            checks++;
            if ({s_count, s_full, s_af, s_ae, s_empty} !==
                {4'(i), (i == 8), (i >= 6), (i <= 2), 1'b0}) begin
                failures++;
                $display("FAIL fill_%0d got cnt=%0d f=%b af=%b ae=%b e=%b want cnt=%0d f=%b af=%b ae=%b e=0",
                         i, s_count, s_full, s_af, s_ae, s_empty, i, (i == 8), (i >= 6), (i <= 2));
            end
            $display("write %h -> count=%0d full=%b af=%b", s_wr_data, s_count, s_full, s_af);
        end
        s_wr_en = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            s_rd_en = 1'b1;
            tick();
            exp_data = 16'(k);
            checks++;
            if ({s_rd_valid, s_rd_data, s_count} !== {1'b1, exp_data, 4'(8 - k)}) begin
                failures++;
                $display("FAIL drain_%0d got v=%b data=%h cnt=%0d want v=1 data=%h cnt=%0d",
                         k, s_rd_valid, s_rd_data, s_count, exp_data, 8 - k);
            end
            $display("read -> data=%h valid=%b count=%0d", s_rd_data, s_rd_valid, s_count);
        end
        s_rd_en = 1'b0;
        tick();
        checks++;
        if ({s_rd_valid, s_rd_data, s_empty, s_unf} !== {1'b0, 16'h0008, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL drain_idle got v=%b data=%h e=%b unf=%b want v=0 data=0008 e=1 unf=0",
                     s_rd_valid, s_rd_data, s_empty, s_unf);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_data;
        for (int i = 0; i < 8; i++) begin
            s_wr_en = 1'b1;
            s_wr_data = 16'h0011 + 16'(i);
            tick();
        end
        s_wr_data = 16'h00AA;
        tick();
        s_wr_en = 1'b0;
        checks++;
        if ({s_ovf, s_count, s_full} !== {1'b1, 4'd8, 1'b1}) begin
            failures++;
            $display("FAIL overflow_set got ovf=%b cnt=%0d f=%b want ovf=1 cnt=8 f=1", s_ovf, s_count, s_full);
        end
        $display("write 00aa while full -> overflow=%b count=%0d", s_ovf, s_count);
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        checks++;
        if (s_ovf !== 1'b0) begin
            failures++;
            $display("FAIL overflow_clear got ovf=%b want 0", s_ovf);
        end
        for (int k = 0; k < 8; k++) begin
            s_rd_en = 1'b1;
            tick();
            exp_data = 16'h0011 + 16'(k);
            checks++;
            if ({s_rd_valid, s_rd_data} !== {1'b1, exp_data}) begin
                failures++;
                $display("FAIL overflow_drain_%0d got v=%b data=%h want v=1 data=%h",
                         k, s_rd_valid, s_rd_data, exp_data);
            end
            $display("read -> data=%h", s_rd_data);
        end
        s_rd_en = 1'b0;
        tick();
    endtask

    task automatic test_full_rw();
        logic [15:0] exp_data;
        for (int i = 0; i < 8; i++) begin
            s_wr_en = 1'b1;
            s_wr_data = 16'h0021 + 16'(i);
            tick();
        end
        s_wr_data = 16'h1234;
        s_rd_en = 1'b1;
        tick();
        s_wr_en = 1'b0;
        checks++;
        if ({s_count, s_full, s_ovf, s_rd_valid, s_rd_data} !== {4'd8, 1'b1, 1'b0, 1'b1, 16'h0021}) begin
            failures++;
            $display("FAIL full_rw got cnt=%0d f=%b ovf=%b v=%b data=%h want 8 1 0 1 0021",
                     s_count, s_full, s_ovf, s_rd_valid, s_rd_data);
        end
        $display("write 1234 + read while full -> count=%0d full=%b data=%h", s_count, s_full, s_rd_data);
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_data = (k == 8) ? 16'h1234 : 16'h0021 + 16'(k);
            checks++;
            if ({s_rd_valid, s_rd_data} !== {1'b1, exp_data}) begin
                failures++;
                $display("FAIL full_rw_drain_%0d got v=%b data=%h want v=1 data=%h",
                         k, s_rd_valid, s_rd_data, exp_data);
            end
            $display("read -> data=%h", s_rd_data);
        end
        s_rd_en = 1'b0;
        tick();
        checks++;
        if (s_empty !== 1'b1) begin
            failures++;
            $display("FAIL full_rw_empty got e=%b want 1", s_empty);
        end
    endtask

    task automatic test_empty_rw();
        s_wr_en = 1'b1;
        s_rd_en = 1'b1;
        s_wr_data = 16'h5555;
        tick();
        s_wr_en = 1'b0;
        s_rd_en = 1'b0;
        checks++;
        if ({s_unf, s_count, s_empty, s_rd_valid} !== {1'b1, 4'd1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL empty_rw got unf=%b cnt=%0d e=%b v=%b want unf=1 cnt=1 e=0 v=0",
                     s_unf, s_count, s_empty, s_rd_valid);
        end
        $display("write 5555 + read while empty -> underflow=%b count=%0d", s_unf, s_count);
        s_rd_en = 1'b1;
        tick();
        checks++;
        if ({s_rd_valid, s_rd_data, s_empty} !== {1'b1, 16'h5555, 1'b1}) begin
            failures++;
            $display("FAIL empty_rw_read got v=%b data=%h e=%b want 1 5555 1", s_rd_valid, s_rd_data, s_empty);
        end
        // Still reading while empty with a clear on the same edge: the new error must win.
        s_clr = 1'b1;
        tick();
        checks++;
        if (s_unf !== 1'b1) begin
            failures++;
            $display("FAIL clr_vs_set got unf=%b want 1", s_unf);
        end
        s_rd_en = 1'b0;
        tick();
        s_clr = 1'b0;
        checks++;
        if (s_unf !== 1'b0) begin
            failures++;
            $display("FAIL underflow_clear got unf=%b want 0", s_unf);
        end
        $display("clr_err -> underflow=%b", s_unf);
    endtask

    task automatic test_fwft_wrap();
        int nread = 0;
        int nwr = 0;
        logic [15:0] exp_data;
        for (int i = 0; i < 3; i++) begin
            f_wr_en = 1'b1;
            f_wr_data = 16'h0100 + 16'(nwr);
            tick();
            nwr++;
            if (i == 0) begin
                checks++;
                if ({f_rd_valid, f_rd_data} !== {1'b1, 16'h0100}) begin
                    failures++;
                    $display("FAIL fwft_first got v=%b data=%h want v=1 data=0100", f_rd_valid, f_rd_data);
                end
            end
        end
        for (int k = 0; k < 9; k++) begin
            f_wr_en = 1'b1;
            f_rd_en = 1'b1;
            f_wr_data = 16'h0100 + 16'(nwr);
            exp_data = 16'h0100 + 16'(nread);
            checks++;
            if ({f_rd_valid, f_rd_data} !== {1'b1, exp_data}) begin
                failures++;
                $display("FAIL fwft_head_%0d got v=%b data=%h want v=1 data=%h",
                         nread, f_rd_valid, f_rd_data, exp_data);
            end
            $display("fwft pop %h push %h", f_rd_data, f_wr_data);
            tick();
            nread++;
            nwr++;
            checks++;
            if (f_count !== 3'd3) begin
                failures++;
                $display("FAIL fwft_count_%0d got cnt=%0d want 3", k, f_count);
            end
        end
        f_wr_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            f_rd_en = 1'b1;
            exp_data = 16'h0100 + 16'(nread);
            checks++;
            if ({f_rd_valid, f_rd_data} !== {1'b1, exp_data}) begin
                failures++;
                $display("FAIL fwft_tail_%0d got v=%b data=%h want v=1 data=%h",
                         nread, f_rd_valid, f_rd_data, exp_data);
            end
            $display("fwft pop %h", f_rd_data);
            tick();
            nread++;
        end
        f_rd_en = 1'b0;
        checks++;
        if ({f_rd_valid, f_empty, f_count, f_unf, f_ovf} !== {1'b0, 1'b1, 3'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL fwft_end got v=%b e=%b cnt=%0d unf=%b ovf=%b want 0 1 0 0 0",
                     f_rd_valid, f_empty, f_count, f_unf, f_ovf);
        end
    endtask

    task automatic test_mid_reset();
        s_rd_en = 1'b1;
        tick();
        s_rd_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_wr_en = 1'b1;
            s_wr_data = 16'h0031 + 16'(i);
            tick();
        end
        s_wr_en = 1'b0;
        checks++;
        if ({s_count, s_unf} !== {4'd3, 1'b1}) begin
            failures++;
            $display("FAIL pre_reset got cnt=%0d unf=%b want cnt=3 unf=1", s_count, s_unf);
        end
        s_rst = 1'b1;
        #1;
        checks++;
        if ({s_count, s_empty} !== {4'd0, 1'b1}) begin
            failures++;
            $display("FAIL async_reset got cnt=%0d e=%b want cnt=0 e=1", s_count, s_empty);
        end
        tick();
        s_rst = 1'b0;
        checks++;
        if ({s_count, s_empty, s_rd_valid, s_unf, s_ovf} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset got cnt=%0d e=%b v=%b unf=%b ovf=%b want 0 1 0 0 0",
                     s_count, s_empty, s_rd_valid, s_unf, s_ovf);
        end
        $display("mid-stream reset -> count=%0d empty=%b", s_count, s_empty);
        s_wr_en = 1'b1;
        s_wr_data = 16'h0F0F;
        tick();
        s_wr_en = 1'b0;
        s_rd_en = 1'b1;
        tick();
        s_rd_en = 1'b0;
        checks++;
        if ({s_rd_valid, s_rd_data, s_empty} !== {1'b1, 16'h0F0F, 1'b1}) begin
            failures++;
            $display("FAIL post_reset_rw got v=%b data=%h e=%b want 1 0f0f 1", s_rd_valid, s_rd_data, s_empty);
        end
        $display("post-reset write/read 0f0f -> data=%h", s_rd_data);
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_rw();
        test_empty_rw();
        test_fwft_wrap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
